// File: rtl/fetch_pipe_if.sv
// fetch_pipe_if: bundles the IF/ID register traffic.
//   master: fetch side. Drives instruction/pc/fetch_valid and the stall/flush
//           controls. Observes the registered slot, fetch_hold, skid_full and
//           overflow_err.
//   slave : the fetch_pipe register itself.
interface fetch_pipe_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int INSTRUCTION = 32
);
  logic [INSTRUCTION-1:0] instruction;
  logic [DATA_WIDTH-1:0]  pc;
  logic                   fetch_valid;
  logic                   stall;
  logic                   flush;
  logic [INSTRUCTION-1:0] instruction_fetch_pp;
  logic [DATA_WIDTH-1:0]  pc_fetch_pp;
  logic                   valid_fetch_pp;
  logic                   fetch_hold;
  logic                   skid_full;
  logic                   overflow_err;

  modport master (
    output instruction, pc, fetch_valid, stall, flush,
    input  instruction_fetch_pp, pc_fetch_pp, valid_fetch_pp,
           fetch_hold, skid_full, overflow_err
  );

  modport slave (
    input  instruction, pc, fetch_valid, stall, flush,
    output instruction_fetch_pp, pc_fetch_pp, valid_fetch_pp,
           fetch_hold, skid_full, overflow_err
  );
endinterface

// File: rtl/fetch_pipe.sv
// fetch_pipe: IF/ID pipeline register with a one-entry skid buffer.
// It registers the fetched instruction and PC with a valid tag. It holds on
// stall, and a flush turns the slot into a NOP bubble. The fetch already in
// flight when a stall arrives is parked in the skid and is presented first
// once the stall releases.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : fetch_pipe_if.slave
//     in : instruction, pc, fetch_valid, stall, flush
//     out: instruction_fetch_pp, pc_fetch_pp, valid_fetch_pp,
//          fetch_hold (stall | skid occupied), skid_full, overflow_err (sticky)
module fetch_pipe #(
  parameter int                     DATA_WIDTH  = 32,
  parameter int                     INSTRUCTION = 32,
  parameter logic [INSTRUCTION-1:0] NOP         = 32'h0000_0013
) (
  input logic        clk,
  input logic        rst,
  fetch_pipe_if.slave bus
);

  logic [INSTRUCTION-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0]  pc_q, pc_d;
  logic                   valid_q, valid_d;
  logic [INSTRUCTION-1:0] skid_instr_q, skid_instr_d;
  logic [DATA_WIDTH-1:0]  skid_pc_q, skid_pc_d;
  logic                   skid_valid_q, skid_valid_d;
  logic                   ovf_q, ovf_d;

  // Priority: flush > stall > normal. Skid content always leaves before the
  // live input, which keeps instructions in fetch order.
  always_comb begin
    instr_d      = instr_q;
    pc_d         = pc_q;
    valid_d      = valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_valid_d = skid_valid_q;
    ovf_d        = ovf_q;

    if (bus.flush) begin
      instr_d      = NOP;
      pc_d         = '0;
      valid_d      = 1'b0;
      skid_valid_d = 1'b0;
    end else if (bus.stall) begin
      if (bus.fetch_valid) begin
        if (skid_valid_q) begin
          ovf_d = 1'b1;
        end else begin
          skid_instr_d = bus.instruction;
          skid_pc_d    = bus.pc;
          skid_valid_d = 1'b1;
        end
      end
    end else if (skid_valid_q) begin
      instr_d = skid_instr_q;
      pc_d    = skid_pc_q;
      valid_d = 1'b1;
      if (bus.fetch_valid) begin
        skid_instr_d = bus.instruction;
        skid_pc_d    = bus.pc;
      end else begin
        skid_valid_d = 1'b0;
      end
    end else if (bus.fetch_valid) begin
      instr_d = bus.instruction;
      pc_d    = bus.pc;
      valid_d = 1'b1;
    end else begin
      instr_d = NOP;
      pc_d    = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q      <= NOP;
      pc_q         <= '0;
      valid_q      <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      skid_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      valid_q      <= valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_valid_q <= skid_valid_d;
      ovf_q        <= ovf_d;
    end
  end

  assign bus.instruction_fetch_pp = instr_q;
  assign bus.pc_fetch_pp          = pc_q;
  assign bus.valid_fetch_pp       = valid_q;
  assign bus.fetch_hold           = bus.stall | skid_valid_q;
  assign bus.skid_full            = skid_valid_q;
  assign bus.overflow_err         = ovf_q;

endmodule

// File: tb/tb_fetch_pipe.sv
module tb_fetch_pipe;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] IA  = 32'h0050_0093;
  localparam logic [31:0] IB  = 32'h00A0_0113;
  localparam logic [31:0] IC  = 32'h00F0_0193;
  localparam logic [31:0] ID  = 32'h0140_0213;
  localparam logic [31:0] IE  = 32'h0190_0293;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;
  bit   chk_en = 1'b0;

  fetch_pipe_if #(.DATA_WIDTH(32), .INSTRUCTION(32)) bus ();

  fetch_pipe #(.DATA_WIDTH(32), .INSTRUCTION(32), .NOP(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model: the pipe is an in-order queue of pending fetches in front of one
  // output slot. While stalled, at most one fetch may wait, and any further
  // fetch is lost. When not stalled, the oldest pending fetch (or a bubble)
  // moves into the slot.
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_ovf;
  logic [63:0] m_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_instr = NOP; m_pc = '0; m_valid = 1'b0; m_ovf = 1'b0;
      m_q.delete();
    end else if (bus.flush) begin
      m_instr = NOP; m_pc = '0; m_valid = 1'b0;
      m_q.delete();
    end else if (bus.stall) begin
      if (bus.fetch_valid) begin
        if (m_q.size() == 0) m_q.push_back({bus.instruction, bus.pc});
        else m_ovf = 1'b1;
      end
    end else begin
      if (bus.fetch_valid) m_q.push_back({bus.instruction, bus.pc});
      if (m_q.size() > 0) begin
        logic [63:0] e;
        e = m_q.pop_front();
        m_instr = e[63:32]; m_pc = e[31:0]; m_valid = 1'b1;
      end else begin
        m_instr = NOP; m_pc = '0; m_valid = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_instr", bus.instruction_fetch_pp, m_instr);
      chk("m_pc",    bus.pc_fetch_pp,          m_pc);
      chk("m_valid", bus.valid_fetch_pp,       m_valid);
      chk("m_skid",  bus.skid_full,            m_q.size() != 0);
      chk("m_ovf",   bus.overflow_err,         m_ovf);
      chk("m_hold",  bus.fetch_hold,           bus.stall | (m_q.size() != 0));
    end
  end

  // Inputs are applied 1 time unit after a rising edge, and then one edge is taken.
  task automatic cyc(input bit fv, input logic [31:0] ins, input logic [31:0] p,
                     input bit st, input bit fl);
    bus.fetch_valid = fv;
    bus.instruction = ins;
    bus.pc          = p;
    bus.stall       = st;
    bus.flush       = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic slot(input string name, input logic [31:0] ins, input logic [31:0] p,
                      input bit v);
    chk({name, "_instr"}, bus.instruction_fetch_pp, ins);
    chk({name, "_pc"},    bus.pc_fetch_pp,          p);
    chk({name, "_valid"}, bus.valid_fetch_pp,       v);
  endtask

  task automatic reset_checks(input string name);
    slot(name, NOP, 32'h0, 1'b0);
    chk({name, "_skid"}, bus.skid_full,    1'b0);
    chk({name, "_ovf"},  bus.overflow_err, 1'b0);
    chk({name, "_hold"}, bus.fetch_hold,   bus.stall);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.instruction = $urandom;
    bus.pc          = $urandom;
    bus.fetch_valid = 1'b1;
    bus.stall       = 1'($urandom_range(0, 1));
    bus.flush       = 1'b0;
    #1 rst = 1'b1;
    #1 reset_checks("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.fetch_valid = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
    chk_en = 1'b1;

    // Streaming
    cyc(1, IA, 32'h0, 0, 0); slot("strA", IA, 32'h0, 1);
    cyc(1, IB, 32'h4, 0, 0); slot("strB", IB, 32'h4, 1);
    cyc(1, IC, 32'h8, 0, 0); slot("strC", IC, 32'h8, 1);
    cyc(0, '0, '0, 0, 0);    slot("strBub", NOP, 32'h0, 0);

    // Stall with skid
    cyc(1, IA, 32'h0, 0, 0);
    cyc(1, IB, 32'h4, 1, 0); slot("st1", IA, 32'h0, 1);
    chk("st1_skid", bus.skid_full, 1'b1); chk("st1_hold", bus.fetch_hold, 1'b1);
    cyc(0, '0, '0, 1, 0);    slot("st2", IA, 32'h0, 1);
    chk("st2_skid", bus.skid_full, 1'b1);
    cyc(0, '0, '0, 1, 0);    slot("st3", IA, 32'h0, 1);
    chk("st3_skid", bus.skid_full, 1'b1);
    bus.stall = 1'b0;
    #1 chk("st_hold_skid", bus.fetch_hold, 1'b1);
    @(posedge clk); #1;
    slot("stRel", IB, 32'h4, 1);
    chk("stRel_skid", bus.skid_full, 1'b0); chk("stRel_hold", bus.fetch_hold, 1'b0);

    // Flush together with stall and an incoming fetch
    cyc(1, IA, 32'h0, 0, 0);
    cyc(1, IB, 32'h4, 1, 0);
    cyc(1, IC, 32'h8, 1, 1); slot("fl", NOP, 32'h0, 0);
    chk("fl_skid", bus.skid_full, 1'b0);
    cyc(0, '0, '0, 0, 0);    slot("flAfter", NOP, 32'h0, 0);

    // Skid drains while reloading from a live fetch
    cyc(1, IA, 32'h0, 0, 0);
    cyc(1, IB, 32'h4, 1, 0);
    cyc(1, IC, 32'h8, 0, 0); slot("rlB", IB, 32'h4, 1); chk("rlB_skid", bus.skid_full, 1'b1);
    cyc(1, ID, 32'hC, 0, 0); slot("rlC", IC, 32'h8, 1); chk("rlC_skid", bus.skid_full, 1'b1);
    cyc(0, '0, '0, 0, 0);    slot("rlD", ID, 32'hC, 1); chk("rlD_skid", bus.skid_full, 1'b0);

    // Overflow
    cyc(1, IA, 32'h0, 0, 0);
    cyc(1, IB, 32'h4, 1, 0);
    chk("ov_pre", bus.overflow_err, 1'b0);
    cyc(1, ID, 32'hC, 1, 0); slot("ov", IA, 32'h0, 1);
    chk("ov_err", bus.overflow_err, 1'b1); chk("ov_skid", bus.skid_full, 1'b1);
    cyc(0, '0, '0, 1, 0);    chk("ov_stick1", bus.overflow_err, 1'b1);
    cyc(0, '0, '0, 0, 0);    slot("ovDrain", IB, 32'h4, 1);
    cyc(0, '0, '0, 0, 1);    chk("ov_stickFl", bus.overflow_err, 1'b1);

    // Bubbles, then a fetch
    cyc(0, '0, '0, 0, 0);    slot("bub1", NOP, 32'h0, 0);
    cyc(0, '0, '0, 0, 0);    slot("bub2", NOP, 32'h0, 0);
    cyc(1, IE, 32'h20, 0, 0); slot("bubE", IE, 32'h20, 1);
    chk("bub_ovf", bus.overflow_err, 1'b1);

    // Asynchronous reset mid-stall with the skid full
    cyc(1, IA, 32'h0, 0, 0);
    cyc(1, IB, 32'h4, 1, 0);
    #2 rst = 1'b1;
    #1 reset_checks("rstMid");
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(0, '0, '0, 0, 0);    slot("rstAfter", NOP, 32'h0, 0);

    // Random traffic, checked against the model
    for (int i = 0; i < 80; i++) begin
      cyc(1'($urandom_range(0, 1)), $urandom, $urandom & 32'hFFFF_FFFC,
          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 9) == 0));
    end
    cyc(0, '0, '0, 0, 0);
    cyc(0, '0, '0, 0, 0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_pipe.md
# fetch_pipe

IF/ID pipeline register of the rv32i five-stage core, sitting between instruction fetch (synchronous instruction memory, one-cycle read latency) and the decode stage whose outputs feed the decode pipeline register. It registers the fetched instruction and its PC and tags them with a valid bit. It holds on a decode stall and replaces flushed slots with a NOP. A one-entry skid buffer catches the instruction already in flight from memory when a stall arrives, so no fetch is lost.

## Interface
- DATA_WIDTH, 32, PC width
- INSTRUCTION, 32, instruction width
- NOP, 32'h0000_0013, bubble encoding (addi x0,x0,0)

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- instruction  input  INSTRUCTION  read data from instruction memory
- pc  input  DATA_WIDTH  PC of `instruction`, aligned with it
- fetch_valid  input  1  `instruction`/`pc` hold a real fetch this cycle
- stall  input  1  decode must hold (load-use hazard)
- flush  input  1  taken branch/jump; kill the slot
- instruction_fetch_pp  output  INSTRUCTION  registered instruction to decode
- pc_fetch_pp  output  DATA_WIDTH  registered PC to decode
- valid_fetch_pp  output  1  output slot holds a real instruction
- fetch_hold  output  1  combinational: stall | skid_valid; PC must not advance
- skid_full  output  1  skid buffer occupied
- overflow_err  output  1  sticky: a fetch was dropped

## Operation
- State: output register (instr_q, pc_q, valid_q), skid (skid_instr, skid_pc, skid_valid), overflow_err.
- Priority per edge is flush > stall > normal.
- flush: instr_q=NOP, pc_q=0, valid_q=0, skid_valid=0. Incoming fetch is discarded. overflow_err is unchanged.
- stall (no flush):
  - Output register holds.
  - If fetch_valid and the skid is empty, the skid captures instruction/pc and skid_valid=1.
  - If fetch_valid and the skid is full, the fetch is dropped and overflow_err=1.
- Normal, skid full:
  - Output loads the skid contents and valid_q=1.
  - If fetch_valid, the skid reloads from the inputs and stays full. Otherwise skid_valid=0.
- Normal, skid empty:
  - If fetch_valid, the output loads the inputs and valid_q=1.
  - Otherwise it loads a bubble: instr_q=NOP, pc_q=0, valid_q=0.
- Ordering: instructions leave in fetch order. Skid content always precedes the inputs.
- Upstream contract: fetch_valid is asserted the cycle after fetch_hold=0. At most one in-flight fetch can arrive after a stall rises.
- overflow_err is cleared only by rst.

## Timing
- Reset (asynchronous, immediate) sets:
  - instruction_fetch_pp=NOP, pc_fetch_pp=0
  - valid_fetch_pp=0, skid_full=0, overflow_err=0
  - fetch_hold then equals stall.
- Latency: input to output is 1 cycle when no stall and the skid is empty.
- Latency via skid: 1 cycle after stall deasserts.
- fetch_hold is combinational from stall and the skid_valid register, with no other path.
- Stall rising with the in-flight fetch: that fetch goes to the skid at the same edge. fetch_hold stays 1 from then until the skid drains.
- Stall for N cycles: output is constant for N edges. The first edge after stall falls presents the skid instruction.
- Simultaneous flush and stall: flush wins. Output becomes a bubble and the skid empties.
- Simultaneous flush and fetch_valid: the fetch is discarded.
- rst mid-stall with the skid full: everything returns to reset values asynchronously and the skid contents are lost.

## Test plan
- Reset: hold rst with random inputs -> instruction_fetch_pp=32'h13, pc_fetch_pp=0, valid=0, skid_full=0, overflow_err=0. Check asynchronously, before any clk edge.
- Streaming: fetch_valid=1 with pc 0x0,0x4,0x8 and instr A,B,C on successive cycles, no stall -> outputs A/0x0, B/0x4, C/0x8 one cycle later each, valid=1.
- Stall with skid:
  - Stimulus: output = A/0x0; stall=1 for 3 cycles while B/0x4 arrives on the first stall cycle.
  - Output holds A for 3 edges. skid_full=1 and fetch_hold=1 throughout.
  - After stall drops, output = B/0x4 and skid_full=0 on the next edge.
- Flush: skid holding B, output A; assert flush together with stall=1 and fetch_valid C -> next edge output NOP/0, valid=0, skid_full=0. C never appears.
- Overflow: skid full, stall=1, fetch_valid=1 with D -> overflow_err=1 and output/skid unchanged. overflow_err stays 1 after stall and flush until rst.
- Bubbles: fetch_valid=0 for 2 cycles with no stall -> two NOP/0 slots with valid=0. The next valid fetch E/0x20 appears one cycle after it is presented.
